// File: rtl/ntt_pkg.sv
// ntt_pkg: shared constants and types for the NTT butterfly datapath.
//   WIDTH   - coefficient/datapath width (23, matches mod_mul)
//   Q_KYBER - Kyber modulus 3329 (select = 1)
//   Q_DIL   - Dilithium modulus 8380417 (select = 0)
package ntt_pkg;

  localparam int WIDTH   = 23;
  localparam int Q_KYBER = 3329;
  localparam int Q_DIL   = 8380417;

  typedef logic [WIDTH-1:0] coeff_t;

  typedef enum logic {
    DILITHIUM = 1'b0,
    KYBER     = 1'b1
  } mode_e;

endpackage

// File: rtl/mod_mul.sv
// mod_mul: combinational modular multiplier, c_o = (a_i * b_i) mod q.
// Ports:
//   a_i, b_i  - operands (WIDTH bits)
//   select_i  - 1 = Kyber modulus, 0 = Dilithium modulus
//   c_o       - fully reduced product (WIDTH bits)
// The product is reduced by a constant modulus in each mode, so operands
// outside [0, q) still produce a result in [0, q).
module mod_mul
  import ntt_pkg::*;
#(
  parameter int MW      = WIDTH,
  parameter int MQ_KYB  = Q_KYBER,
  parameter int MQ_DIL  = Q_DIL
) (
  input  logic [MW-1:0] a_i,
  input  logic [MW-1:0] b_i,
  input  logic          select_i,
  output logic [MW-1:0] c_o
);

  localparam int PW = 2 * MW;

  logic [PW-1:0] prod_s;
  logic [PW-1:0] rem_kyb_s;
  logic [PW-1:0] rem_dil_s;

  // Full-width product and per-mode constant-modulus reduction.
  always_comb begin
    prod_s    = {{MW{1'b0}}, a_i} * {{MW{1'b0}}, b_i};
    rem_kyb_s = prod_s % PW'(MQ_KYB);
    rem_dil_s = prod_s % PW'(MQ_DIL);
    if (select_i) begin
      c_o = MW'(rem_kyb_s);
    end else begin
      c_o = MW'(rem_dil_s);
    end
  end

endmodule

// File: rtl/ntt_butterfly_pipe_mod_addsub.sv
// mod_addsub: combinational modular add/subtract for the butterfly.
//   sum_o  = (a_i + t_i) mod q
//   diff_o = (a_i - t_i) mod q
// Ports: a_i, t_i (WIDTH), select_i (1 = Kyber), sum_o, diff_o (WIDTH).
// Optional macro NTT_BFLY_HALF_EN adds half_i: when set, each result x is
// replaced by x/2 mod q (inverse-NTT scaling).
module mod_addsub
  import ntt_pkg::*;
#(
  parameter int AW     = WIDTH,
  parameter int AQ_KYB = Q_KYBER,
  parameter int AQ_DIL = Q_DIL
) (
  input  logic [AW-1:0] a_i,
  input  logic [AW-1:0] t_i,
  input  logic          select_i,
`ifdef NTT_BFLY_HALF_EN
  input  logic          half_i,
`endif
  output logic [AW-1:0] sum_o,
  output logic [AW-1:0] diff_o
);

  localparam logic [AW:0] QK = (AW+1)'(AQ_KYB);
  localparam logic [AW:0] QD = (AW+1)'(AQ_DIL);

  logic [AW:0] q_s;
  logic [AW:0] sum_raw_s;
  logic [AW:0] sum_red_s;
  logic [AW:0] diff_red_s;
  logic [AW:0] sum_fin_s;
  logic [AW:0] diff_fin_s;

  // One extra bit holds a+t before the conditional subtract; a-t+q wraps
  // modulo 2^(AW+1) and lands on the correct residue.
  always_comb begin
    if (select_i) begin
      q_s = QK;
    end else begin
      q_s = QD;
    end
    sum_raw_s = {1'b0, a_i} + {1'b0, t_i};
    if (sum_raw_s >= q_s) begin
      sum_red_s = sum_raw_s - q_s;
    end else begin
      sum_red_s = sum_raw_s;
    end
    if (a_i < t_i) begin
      diff_red_s = {1'b0, a_i} - {1'b0, t_i} + q_s;
    end else begin
      diff_red_s = {1'b0, a_i} - {1'b0, t_i};
    end
  end

`ifdef NTT_BFLY_HALF_EN
  // x/2 mod q: odd x becomes even after adding the odd modulus.
  always_comb begin
    if (half_i && sum_red_s[0]) begin
      sum_fin_s = (sum_red_s + q_s) >> 1;
    end else if (half_i) begin
      sum_fin_s = sum_red_s >> 1;
    end else begin
      sum_fin_s = sum_red_s;
    end
    if (half_i && diff_red_s[0]) begin
      diff_fin_s = (diff_red_s + q_s) >> 1;
    end else if (half_i) begin
      diff_fin_s = diff_red_s >> 1;
    end else begin
      diff_fin_s = diff_red_s;
    end
  end
`else
  // Plain results pass straight through.
  always_comb begin
    sum_fin_s  = sum_red_s;
    diff_fin_s = diff_red_s;
  end
`endif

  assign sum_o  = AW'(sum_fin_s);
  assign diff_o = AW'(diff_fin_s);

endmodule

// File: rtl/ntt_butterfly_pipe.sv
// ntt_butterfly_pipe: two-stage Cooley-Tukey butterfly with valid/ready.
//   S1 registers a, t = b*w mod q (via mod_mul) and the mode.
//   S2 registers out0 = (a+t) mod q, out1 = (a-t) mod q and the mode.
// Ports:
//   clk_i, rst_n_i (async active-low)
//   in_valid_i / in_ready_o, select_i (1 = Kyber), a_i, b_i, w_i
//   out_valid_o / out_ready_i, select_o, out0_o, out1_o
// Optional macro NTT_BFLY_HALF_EN adds half_i (latched per transaction)
// selecting x/2 mod q scaling of both results.
module ntt_butterfly_pipe
  import ntt_pkg::*;
#(
  parameter int WIDTH   = ntt_pkg::WIDTH,
  parameter int Q_KYBER = ntt_pkg::Q_KYBER,
  parameter int Q_DIL   = ntt_pkg::Q_DIL
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             select_i,
`ifdef NTT_BFLY_HALF_EN
  input  logic             half_i,
`endif
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] w_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             select_o,
  output logic [WIDTH-1:0] out0_o,
  output logic [WIDTH-1:0] out1_o
);

  logic [WIDTH-1:0] t_s;
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] diff_s;
  logic             s2_adv_s;
  logic             s1_adv_s;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q,     s1_a_d;
  logic [WIDTH-1:0] s1_t_q,     s1_t_d;
  mode_e            s1_sel_q,   s1_sel_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out0_q,     out0_d;
  logic [WIDTH-1:0] out1_q,     out1_d;
  logic             sel_o_q,    sel_o_d;
`ifdef NTT_BFLY_HALF_EN
  logic             s1_half_q,  s1_half_d;
`endif

  mod_mul #(
    .MW     (WIDTH),
    .MQ_KYB (Q_KYBER),
    .MQ_DIL (Q_DIL)
  ) u_mod_mul (
    .a_i      (b_i),
    .b_i      (w_i),
    .select_i (select_i),
    .c_o      (t_s)
  );

  mod_addsub #(
    .AW     (WIDTH),
    .AQ_KYB (Q_KYBER),
    .AQ_DIL (Q_DIL)
  ) u_mod_addsub (
    .a_i      (s1_a_q),
    .t_i      (s1_t_q),
    .select_i (s1_sel_q == KYBER),
`ifdef NTT_BFLY_HALF_EN
    .half_i   (s1_half_q),
`endif
    .sum_o    (sum_s),
    .diff_o   (diff_s)
  );

  // Stall chain: a stage advances when its downstream slot is free or
  // draining this cycle, so a full pipe streams without bubbles.
  always_comb begin
    s2_adv_s = !out_valid_q || out_ready_i;
    s1_adv_s = !s1_valid_q || s2_adv_s;
  end

  assign in_ready_o = s1_adv_s;

  // Next-state for S1: capture on input handshake, otherwise hold.
  always_comb begin
    s1_valid_d = s1_adv_s ? in_valid_i : s1_valid_q;
    if (s1_adv_s && in_valid_i) begin
      s1_a_d   = a_i;
      s1_t_d   = t_s;
      s1_sel_d = mode_e'(select_i);
    end else begin
      s1_a_d   = s1_a_q;
      s1_t_d   = s1_t_q;
      s1_sel_d = s1_sel_q;
    end
  end

`ifdef NTT_BFLY_HALF_EN
  // Scaling flag travels with the S1 transaction.
  always_comb begin
    if (s1_adv_s && in_valid_i) begin
      s1_half_d = half_i;
    end else begin
      s1_half_d = s1_half_q;
    end
  end
`endif

  // Next-state for S2: take the S1 result when advancing, otherwise hold.
  always_comb begin
    out_valid_d = s2_adv_s ? s1_valid_q : out_valid_q;
    if (s2_adv_s && s1_valid_q) begin
      out0_d  = sum_s;
      out1_d  = diff_s;
      sel_o_d = (s1_sel_q == KYBER);
    end else begin
      out0_d  = out0_q;
      out1_d  = out1_q;
      sel_o_d = sel_o_q;
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_t_q      <= '0;
      s1_sel_q    <= DILITHIUM;
      out_valid_q <= 1'b0;
      out0_q      <= '0;
      out1_q      <= '0;
      sel_o_q     <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_t_q      <= s1_t_d;
      s1_sel_q    <= s1_sel_d;
      out_valid_q <= out_valid_d;
      out0_q      <= out0_d;
      out1_q      <= out1_d;
      sel_o_q     <= sel_o_d;
    end
  end

`ifdef NTT_BFLY_HALF_EN
  // Scaling flag register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_half_q <= 1'b0;
    end else begin
      s1_half_q <= s1_half_d;
    end
  end
`endif

  assign out_valid_o = out_valid_q;
  assign out0_o      = out0_q;
  assign out1_o      = out1_q;
  assign select_o    = sel_o_q;

endmodule

// File: tb/tb_ntt_butterfly_pipe.sv
// Scoreboard bench for ntt_butterfly_pipe: the driver pushes expected
// results, a monitor pops and compares on each output handshake.
module tb_ntt_butterfly_pipe;

  localparam int W = 23;

  typedef struct packed {
    logic         sel;
    logic [W-1:0] o0;
    logic [W-1:0] o1;
  } exp_t;

  logic         clk_i = 1'b0;
  logic         rst_n_i = 1'b0;
  logic         in_valid_i = 1'b0;
  logic         in_ready_o;
  logic         select_i = 1'b0;
  logic         half_i = 1'b0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic [W-1:0] w_i = '0;
  logic         out_valid_o;
  logic         out_ready_i = 1'b1;
  logic         select_o;
  logic [W-1:0] out0_o;
  logic [W-1:0] out1_o;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   bp_mode = 0;   // 0: ready high, 1: ready low, 2: random
  bit   in_reset = 1'b1;

  ntt_butterfly_pipe dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .select_i    (select_i),
`ifdef NTT_BFLY_HALF_EN
    .half_i      (half_i),
`endif
    .a_i         (a_i),
    .b_i         (b_i),
    .w_i         (w_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .select_o    (select_o),
    .out0_o      (out0_o),
    .out1_o      (out1_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input longint unsigned act,
                       input longint unsigned expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Reference: butterfly from the modular-arithmetic definition.
  function automatic exp_t model(bit sel, longint unsigned a, longint unsigned b,
                                 longint unsigned w, bit half);
    longint unsigned q, t, s, d;
    exp_t e;
    q = sel ? 64'd3329 : 64'd8380417;
    t = (b * w) % q;
    s = (a + t) % q;
    d = (a + q - t) % q;
    if (half) begin
      s = (s % 2 == 0) ? s / 2 : (s + q) / 2;
      d = (d % 2 == 0) ? d / 2 : (d + q) / 2;
    end
    e.sel = sel;
    e.o0  = W'(s);
    e.o1  = W'(d);
    return e;
  endfunction

  // Present one transaction, wait (bounded) for acceptance, push expectation.
  task automatic send(input bit sel, input int unsigned a, input int unsigned b,
                      input int unsigned w, input bit half, input exp_t e);
    bit done;
    done = 1'b0;
    @(negedge clk_i);
    in_valid_i = 1'b1;
    select_i   = sel;
    half_i     = half;
    a_i = W'(a);
    b_i = W'(b);
    w_i = W'(w);
    for (int k = 0; k < 60 && !done; k++) begin
      #1;
      if (in_ready_o) begin
        exp_q.push_back(e);
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        done = 1'b1;
      end else begin
        @(negedge clk_i);
      end
    end
    if (!done) begin
      check("send_timeout", 0, 1);
      in_valid_i = 1'b0;
    end
  endtask

  task automatic send_m(input bit sel, input int unsigned a, input int unsigned b,
                        input int unsigned w, input bit half);
    send(sel, a, b, w, half, model(sel, a, b, w, half));
  endtask

  function automatic exp_t mk(bit sel, int unsigned o0, int unsigned o1);
    exp_t e;
    e.sel = sel;
    e.o0  = W'(o0);
    e.o1  = W'(o1);
    return e;
  endfunction

  task automatic drain();
    int n;
    @(posedge clk_i);
    #1 bp_mode = 0;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk_i);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Downstream ready generator.
  always @(negedge clk_i) begin
    case (bp_mode)
      0:       out_ready_i = 1'b1;
      1:       out_ready_i = 1'b0;
      default: out_ready_i = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: compare on handshake, enforce hold stability under stall.
  initial begin
    exp_t e;
    bit   prev_hold;
    logic [W-1:0] p0, p1;
    logic ps;
    prev_hold = 1'b0;
    p0 = '0; p1 = '0; ps = 1'b0;
    forever begin
      @(negedge clk_i);
      #2;
      if (in_reset || !rst_n_i) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          check("hold_valid", out_valid_o, 1);
          check("hold_out0", out0_o, p0);
          check("hold_out1", out1_o, p1);
          check("hold_sel", select_o, ps);
        end
        if (out_valid_o && out_ready_i) begin
          if (exp_q.size() == 0) begin
            check("spurious_output", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("out0", out0_o, e.o0);
            check("out1", out1_o, e.o1);
            check("select_o", select_o, e.sel);
          end
        end
        prev_hold = out_valid_o && !out_ready_i;
        p0 = out0_o; p1 = out1_o; ps = select_o;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state.
    #1;
    check("rst_out_valid", out_valid_o, 0);
    check("rst_out0", out0_o, 0);
    check("rst_out1", out1_o, 0);
    check("rst_select_o", select_o, 0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_n_i  = 1'b1;
    in_reset = 1'b0;
    @(posedge clk_i);
    #1 check("post_rst_in_ready", in_ready_o, 1);

    // Directed vectors from the butterfly definition.
    send(1'b1, 100, 5, 7, 1'b0, mk(1'b1, 135, 65));
    send(1'b1, 3300, 1, 100, 1'b0, mk(1'b1, 71, 3200));
    send(1'b1, 10, 1, 20, 1'b0, mk(1'b1, 30, 3319));
    send(1'b1, 0, 4096, 4096, 1'b0, mk(1'b1, 2385, 944));
    send(1'b0, 8380416, 2, 1, 1'b0, mk(1'b0, 1, 8380414));
    send(1'b1, 3000, 1, 329, 1'b0, mk(1'b1, 0, 2671));      // a+t = q
    send(1'b0, 777, 1, 777, 1'b0, mk(1'b0, 1554, 0));       // a = t
    send(1'b1, 3328, 1, 3328, 1'b0, mk(1'b1, 3327, 0));     // q-1, q-1
`ifdef NTT_BFLY_HALF_EN
    send(1'b1, 100, 5, 7, 1'b1, mk(1'b1, 1732, 1697));
`endif
    drain();

    // Backpressure: two fill the pipe, two wait for release.
    @(posedge clk_i);
    #1 bp_mode = 1;
    send(1'b1, 11, 2, 3, 1'b0, mk(1'b1, 17, 5));
    send(1'b0, 500, 3, 4, 1'b0, mk(1'b0, 512, 488));
    check("bp_in_ready_low", in_ready_o, 0);
    check("bp_out_valid", out_valid_o, 1);
    fork
      begin
        repeat (3) @(posedge clk_i);
        #1 bp_mode = 0;
      end
    join_none
    send(1'b1, 1, 1, 1, 1'b0, mk(1'b1, 2, 0));
    send(1'b0, 0, 1, 5, 1'b0, mk(1'b0, 5, 8380412));
    drain();

    // Reset with two transactions in flight.
    send_m(1'b1, 1234, 56, 78, 1'b0);
    send_m(1'b0, 4321, 99, 12345, 1'b0);
    #2;
    in_reset = 1'b1;
    rst_n_i  = 1'b0;
    #1;
    check("midrst_out_valid", out_valid_o, 0);
    check("midrst_out0", out0_o, 0);
    check("midrst_out1", out1_o, 0);
    exp_q.delete();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_n_i  = 1'b1;
    in_reset = 1'b0;
    @(negedge clk_i);
    in_valid_i = 1'b1;
    select_i = 1'b1; half_i = 1'b0;
    a_i = W'(100); b_i = W'(5); w_i = W'(7);
    #1 check("lat_in_ready", in_ready_o, 1);
    exp_q.push_back(mk(1'b1, 135, 65));
    @(posedge clk_i);
    #1 in_valid_i = 1'b0;
    check("lat_cycle1", out_valid_o, 0);
    @(posedge clk_i);
    #1 check("lat_cycle2", out_valid_o, 1);
    drain();

    // Randomized mixed traffic with random backpressure.
    @(posedge clk_i);
    #1 bp_mode = 2;
    for (int i = 0; i < 150; i++) begin
      bit sel, hf;
      int unsigned q;
      sel = $urandom_range(0, 1);
`ifdef NTT_BFLY_HALF_EN
      hf = $urandom_range(0, 1);
`else
      hf = 1'b0;
`endif
      q = sel ? 3329 : 8380417;
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
      send_m(sel, $urandom_range(0, q - 1), $urandom_range(0, q - 1),
             $urandom_range(0, q - 1), hf);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
